// File: rtl/cmpe200_pkg.sv
// ---------------------------------------------------------------------------
// cmpe200_pkg
// Constants and helpers shared by the pipeline-register blocks.
//   DATA_W         : default datapath width of a pipeline register
//   PIPE_RESET_VAL : default value loaded into pipeline data on reset
//   clog2()        : ceiling log2, usable in parameter expressions
// ---------------------------------------------------------------------------
package cmpe200_pkg;

    localparam int                DATA_W         = 16;
    localparam logic [DATA_W-1:0] PIPE_RESET_VAL = '0;

    // Number of bits needed to encode the values 0..value-1.
    function automatic int clog2(input int value);
        int res;
        int v;
        res = 0;
        v   = value - 1;
        while (v > 0) begin
            res = res + 1;
            v   = v >> 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/d_ff_pipe_stage.sv
// ---------------------------------------------------------------------------
// d_ff_pipe_stage
// One register slice of d_ff_pipe: a valid bit plus a data word.
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset (valid=0, data=RESET_VAL)
//   flush : clear the valid bit, data word holds
//   adv   : stage may take a new value this cycle
//   vin   : incoming valid (from the previous stage or the pipe input)
//   din   : incoming data
//   vout  : this stage's valid bit
//   dout  : this stage's data word
// ---------------------------------------------------------------------------
module d_ff_pipe_stage #(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             adv,
    input  logic             vin,
    input  logic [WIDTH-1:0] din,
    output logic             vout,
    output logic [WIDTH-1:0] dout
);

    logic             vld_q;
    logic [WIDTH-1:0] data_q;

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every stage samples its neighbour's pre-edge value and the chain shifts
    // by exactly one slot per edge regardless of evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= 1'b0;
            data_q <= RESET_VAL;
        end else if (flush) begin
            vld_q  <= 1'b0;
        end else if (adv) begin
            vld_q  <= vin;
            // A bubble moving in leaves the old word in place, so the last
            // stage keeps showing stale data instead of toggling on idle cycles.
            if (vin) begin
                data_q <= din;
            end
        end
    end

    assign vout = vld_q;
    assign dout = data_q;

endmodule

// File: rtl/d_ff_pipe.sv
// ---------------------------------------------------------------------------
// d_ff_pipe
// Parametrised pipeline register with valid/ready handshake, bubble
// collapsing, flush and occupancy count. Stage 0 is fed from the input,
// stage DEPTH-1 drives the outputs.
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset, overrides everything
//   flush     : discard all held entries at the next edge
//   in_valid  : upstream offers in_data
//   in_ready  : pipe accepts in_data this cycle
//   in_data   : upstream payload
//   out_valid : out_data is valid
//   out_ready : downstream accepts out_data this cycle
//   out_data  : payload of the last stage (driven even when not valid)
//   count     : number of stages holding valid data, 0..DEPTH
// ---------------------------------------------------------------------------
module d_ff_pipe
    import cmpe200_pkg::*;
#(
    parameter  int               WIDTH     = DATA_W,
    parameter  int               DEPTH     = 2,
    parameter  logic [WIDTH-1:0] RESET_VAL = WIDTH'(PIPE_RESET_VAL),
    localparam int               CW        = clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    count
);

    logic [DEPTH-1:0] vld;
    logic [DEPTH-1:0] adv;
    logic [WIDTH-1:0] data [DEPTH];

    // A stage may advance if it is empty or everything downstream of it can
    // move. Unrolled as a running OR from the output end so adv never reads
    // itself, which keeps the chain free of combinational feedback.
    always_comb begin
        logic run;
        run = out_ready;
        adv = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            run    = run | ~vld[i];
            adv[i] = run;
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        logic             vin;
        logic [WIDTH-1:0] din;

        if (g == 0) begin : g_head
            assign vin = in_valid;
            assign din = in_data;
        end else begin : g_body
            assign vin = vld[g-1];
            assign din = data[g-1];
        end

        d_ff_pipe_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk   (clk),
            .rst   (rst),
            .flush (flush),
            .adv   (adv[g]),
            .vin   (vin),
            .din   (din),
            .vout  (vld[g]),
            .dout  (data[g])
        );
    end

    // Occupancy depends on the valid registers only, never on the handshake.
    always_comb begin
        count = '0;
        for (int i = 0; i < DEPTH; i++) begin
            count = count + CW'(vld[i]);
        end
    end

    // Flush masks both ends so no transfer happens in the cycle it is applied.
    assign in_ready  = adv[0] & ~flush;
    assign out_valid = vld[DEPTH-1] & ~flush;
    assign out_data  = data[DEPTH-1];

endmodule

// File: tb/tb_d_ff_pipe.sv
// ---------------------------------------------------------------------------
// tb_d_ff_pipe
// Directed bench for d_ff_pipe: a DEPTH=3 / WIDTH=16 instance (RESET_VAL
// 16'hDEAD) and a DEPTH=1 / WIDTH=8 instance (RESET_VAL 8'h5A) sharing clk
// and rst. Inputs change 1 time unit after the rising edge, outputs are
// sampled 1 time unit later, well before the next edge.
// ---------------------------------------------------------------------------
module tb_d_ff_pipe;

    logic clk;
    logic rst;

    // DEPTH=3 instance
    logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [15:0] a_in_data, a_out_data;
    logic [1:0]  a_count;

    // DEPTH=1 instance
    logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [7:0]  b_in_data, b_out_data;
    logic [0:0]  b_count;

    int checks;
    int errors;

    d_ff_pipe #(
        .WIDTH     (16),
        .DEPTH     (3),
        .RESET_VAL (16'hDEAD)
    ) u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .flush     (a_flush),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_data   (a_in_data),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_data  (a_out_data),
        .count     (a_count)
    );

    d_ff_pipe #(
        .WIDTH     (8),
        .DEPTH     (1),
        .RESET_VAL (8'h5A)
    ) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .flush     (b_flush),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_data   (b_in_data),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_data  (b_out_data),
        .count     (b_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n_out;

        checks      = 0;
        errors      = 0;
        rst         = 1'b1;
        a_flush     = 1'b0;
        a_in_valid  = 1'b0;
        a_in_data   = '0;
        a_out_ready = 1'b0;
        b_flush     = 1'b0;
        b_in_valid  = 1'b0;
        b_in_data   = '0;
        b_out_ready = 1'b0;

        // ---------------- reset ----------------
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rst_out_valid", a_out_valid, 0);
        check("rst_out_data",  a_out_data,  32'hDEAD);
        check("rst_count",     a_count,     0);
        check("rst_in_ready",  a_in_ready,  1);
        check("rst_b_out_data", b_out_data, 32'h5A);
        check("rst_b_count",    b_count,    0);

        // ---------------- fill and stall ----------------
        a_out_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            a_in_valid = 1'b1;
            a_in_data  = 16'(k);
            #1;
            check("fill_in_ready", a_in_ready, (k <= 3) ? 1 : 0);
        end
        // After the loop: three accepts done, 4 still offered.
        tick();
        check("fill_count",     a_count,     3);
        check("fill_out_data",  a_out_data,  32'h0001);
        check("fill_out_valid", a_out_valid, 1);
        check("full_stall_in_ready", a_in_ready, 0);

        // Full with out_ready=1: accept 4 and emit 1 in the same cycle.
        a_out_ready = 1'b1;
        #1;
        check("full_pass_in_ready", a_in_ready, 1);
        tick();
        check("full_pass_count",    a_count,    3);
        check("full_pass_out_data", a_out_data, 32'h0002);

        // Drain; the last word stays visible once empty.
        a_in_valid = 1'b0;
        tick();
        check("drain_out_data_3", a_out_data, 32'h0003);
        check("drain_count_2",    a_count,    2);
        tick();
        check("drain_out_data_4", a_out_data, 32'h0004);
        tick();
        check("empty_count",     a_count,     0);
        check("empty_out_valid", a_out_valid, 0);
        check("empty_stale",     a_out_data,  32'h0004);

        // ---------------- streaming ----------------
        n_out = 0;
        a_out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            a_in_valid = (c < 10);
            a_in_data  = 16'(c + 1);
            #1;
            if (c < 10) check("stream_in_ready", a_in_ready, 1);
            if (a_out_valid) begin
                check("stream_data",  a_out_data, n_out + 1);
                check("stream_cycle", c,          n_out + 3);
                n_out++;
            end
            tick();
        end
        check("stream_total", n_out, 10);
        check("stream_empty", a_count, 0);

        // ---------------- bubble collapse ----------------
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_data   = 16'h00B0;
        tick();
        a_in_valid  = 1'b0;
        tick();
        a_in_valid  = 1'b1;
        a_in_data   = 16'h00A0;
        tick();
        // Now [A, -, B]
        check("bubble_count_before", a_count,    2);
        check("bubble_out_data",     a_out_data, 32'h00B0);
        a_in_data = 16'h00C0;
        #1;
        check("bubble_in_ready", a_in_ready, 1);
        tick();
        // Now [C, A, B]
        check("bubble_count_after", a_count, 3);
        a_in_data = 16'h00D0;
        #1;
        check("bubble_full_in_ready", a_in_ready, 0);
        tick();
        check("stall_out_data_stable", a_out_data, 32'h00B0);
        check("stall_count",           a_count,    3);

        // ---------------- flush while full ----------------
        a_flush     = 1'b1;
        a_in_valid  = 1'b1;
        a_in_data   = 16'h00E0;
        a_out_ready = 1'b1;
        #1;
        check("flush_in_ready",  a_in_ready,  0);
        check("flush_out_valid", a_out_valid, 0);
        tick();
        a_flush    = 1'b0;
        a_in_data  = 16'h0077;
        #1;
        check("flush_count",     a_count,    0);
        check("flush_data_hold", a_out_data, 32'h00B0);
        check("post_flush_in_ready", a_in_ready, 1);
        tick();
        a_in_valid = 1'b0;
        tick();
        check("post_flush_not_yet", a_out_valid, 0);
        tick();
        check("post_flush_valid", a_out_valid, 1);
        check("post_flush_data",  a_out_data,  32'h0077);
        tick();
        check("post_flush_drained", a_count, 0);

        // ---------------- reset mid-stream ----------------
        a_out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            a_in_valid = 1'b1;
            a_in_data  = 16'(c + 1);
            tick();
        end
        rst       = 1'b1;
        a_in_data = 16'h0006;
        tick();
        rst        = 1'b0;
        a_in_valid = 1'b0;
        #1;
        check("midrst_count",     a_count,     0);
        check("midrst_out_valid", a_out_valid, 0);
        check("midrst_out_data",  a_out_data,  32'hDEAD);
        repeat (3) tick();
        check("midrst_no_ghost", a_out_valid, 0);

        // ---------------- DEPTH=1 instance ----------------
        b_out_ready = 1'b0;
        #1;
        check("d1_empty_in_ready", b_in_ready, 1);
        b_in_valid = 1'b1;
        b_in_data  = 8'h11;
        tick();
        b_in_valid = 1'b0;
        #1;
        check("d1_latency_valid", b_out_valid, 1);
        check("d1_latency_data",  b_out_data,  32'h11);
        check("d1_count_full",    b_count,     1);
        check("d1_full_stall",    b_in_ready,  0);
        b_out_ready = 1'b1;
        #1;
        check("d1_full_pass", b_in_ready, 1);
        b_in_valid = 1'b1;
        b_in_data  = 8'h22;
        tick();
        b_in_valid = 1'b0;
        #1;
        check("d1_pass_data",  b_out_data, 32'h22);
        check("d1_pass_count", b_count,    1);
        tick();
        check("d1_empty_valid", b_out_valid, 0);
        check("d1_empty_stale", b_out_data,  32'h22);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
